i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
I2S master transmitter that serialises stereo PCM samples onto BCLK/LRCLK/SDATA for an external DAC. It sits directly downstream of the sine-sample source in the i2s_sinewave design. It runs on the PLL-derived core clock and consumes one left/right sample pair per frame through a valid/ready handshake, with a one-entry holding buffer. It generates its own bit clock by integer division of the core clock.

Parameters:
SAMPLE_WIDTH, 16, bits per channel slot; frame = 2*SAMPLE_WIDTH BCLK periods
BCLK_DIV, 4, core-clock cycles per BCLK half-period; legal range >= 1

Ports:
clk  input  1  core clock from PLL
RST  input  1  asynchronous active-low reset
in_left  input  SAMPLE_WIDTH  left sample, two's complement
in_right  input  SAMPLE_WIDTH  right sample, two's complement
in_valid  input  1  sample pair valid
in_ready  output  1  holding buffer empty; transfer occurs when in_valid && in_ready at a clk edge
i2s_bclk  output  1  bit clock
i2s_lrclk  output  1  word select: 0 = left, 1 = right
i2s_sdata  output  1  serial data, MSB first, one-BCLK I2S delay
underrun  output  1  one-clk pulse: frame started with empty holding buffer

Behaviour:
- Reset values (RST low, asynchronous): i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, in_ready=1, underrun=0, divider=0, frame position=2W-1, shift and holding registers=0. Here W=SAMPLE_WIDTH.
- Reset asserted mid-frame aborts the frame immediately. A pending held sample is discarded.
- Divider: div_cnt counts 0..BCLK_DIV-1. When div_cnt==BCLK_DIV-1: div_cnt<=0 and bclk toggles. BCLK period = 2*BCLK_DIV clk.
- After reset release, the first rising BCLK edge occurs at clk edge BCLK_DIV and the first falling edge at clk edge 2*BCLK_DIV.
- Falling-edge event is the clk edge where bclk goes 1->0. All serial outputs update on that same clk edge (registered); nothing else changes them.
- On each falling event, pos advances modulo 2W (2W-1 wraps to 0). Then lrclk <= (new pos >= W).
- sdata <= MSB of the 2W-bit shift register, and the shift register shifts left by one. This gives the one-BCLK delay: the left MSB appears one BCLK after lrclk falls. At pos 0, sdata carries the previous frame's right LSB.
- Frame load on the falling event with new pos==0, after the shift-out of that edge:
  - Holding buffer full: shift register <= {held_left, held_right}, buffer becomes empty.
  - Holding buffer empty: shift register <= 0 and underrun pulses high for exactly one clk.
- Holding buffer:
  - in_ready = buffer empty (registered).
  - An accept (in_valid && in_ready) loads the buffer and drops in_ready on the next clk.
  - If an accept and a frame load occur in the same clk, the load uses the old (empty) buffer state: zeros plus an underrun pulse. The newly accepted pair waits for the next frame.
- in_left/in_right are sampled only on accept; changes while in_ready=0 are ignored.
- No back-pressure on the DAC side; the frame rate is fixed at clk/(4*W*BCLK_DIV).

Decomposition:
- Shared include i2s_defs: default SAMPLE_WIDTH, BCLK_DIV, and the lrclk encoding constants (LEFT=0, RIGHT=1).
- One sub-module i2s_clkgen: divider plus bclk register, emitting a one-clk fall_evt strobe.
- i2s_tx holds pos, the shift register, the holding buffer and the handshake.

Test Plan (W=16, BCLK_DIV=2, frame = 128 clk):
- Reset release, no in_valid: bclk first rises at clk 2 and falls at clk 4; lrclk=0 from clk 4; underrun pulses once at clk 4 and every 128 clk thereafter; sdata stays 0.
- Present L=16'hA5F0, R=16'h0F0F before the first frame: in_ready drops one clk after the accept. Over pos 1..16, sdata = 1010010111110000. At pos 16, lrclk=1 and sdata = L LSB (0). Pos 17..31 plus next pos 0 carry 0000111100001111.
- Hold in_valid high with a new pair every accept: no underrun after the first frame; in_ready returns high exactly at each pos-0 falling event.
- Accept coinciding with a pos-0 event: underrun pulses, that frame is zeros, and the accepted pair is transmitted in the following frame.
- Assert RST at pos 20 mid-frame: outputs return to reset values asynchronously; after release, timing restarts as in scenario 1 and the old held sample never appears.
- BCLK_DIV=1: bclk toggles every clk; sdata for L=16'h8001 shows 1 at pos 1 and pos 16.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S transmitter: default geometry and the
// word-select encoding.
package i2s_tx_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_BCLK_DIV     = 4;

  // Word-select levels on i2s_lrclk.
  localparam logic LRCLK_LEFT  = 1'b0;
  localparam logic LRCLK_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock generator: divides the core clock down to BCLK and flags the
// core-clock edge on which BCLK falls.
module i2s_tx_clkgen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_evt
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          half_done;

  assign half_done = (div_cnt == CNT_LAST);

  // High during the cycle whose closing edge takes bclk from 1 to 0, so the
  // consumer updates its registers on that same edge.
  assign fall_evt = half_done && bclk;

  // Half-period counter; bclk toggles each time it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter. Serialises one left/right PCM pair per frame,
// MSB first with the standard one-BCLK delay after word-select changes.
//
// Handshake: a pair transfers on a clk edge where in_valid && in_ready.
// in_ready is a registered "holding buffer empty" flag; it drops the cycle
// after a transfer and rises again on the falling-BCLK edge that moves the
// held pair into the shift register (frame position 0). in_left/in_right
// are sampled only on transfer.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int BCLK_DIV     = DEF_BCLK_DIV
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    underrun
);

  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int PW = $clog2(FW);
  localparam logic [PW-1:0] POS_LAST  = PW'(FW - 1);
  localparam logic [PW-1:0] POS_RIGHT = PW'(SAMPLE_WIDTH);

  logic                    fall_evt;
  logic [PW-1:0]           pos;
  logic [PW-1:0]           pos_nxt;
  logic [FW-1:0]           shreg;
  logic [SAMPLE_WIDTH-1:0] held_left;
  logic [SAMPLE_WIDTH-1:0] held_right;
  logic                    frame_load;
  logic                    accept;

  i2s_tx_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (RST),
    .bclk     (i2s_bclk),
    .fall_evt (fall_evt)
  );

  assign pos_nxt    = (pos == POS_LAST) ? '0 : pos + PW'(1);
  assign frame_load = fall_evt && (pos_nxt == '0);
  assign accept     = in_valid && in_ready;

  // Serial side: frame position, word select, data shift-out and frame load.
  // The bit shifted out at position 0 is the previous frame's right LSB,
  // which is what produces the one-BCLK delay.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pos       <= POS_LAST;
      i2s_lrclk <= LRCLK_RIGHT;
      i2s_sdata <= 1'b0;
      shreg     <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall_evt) begin
        pos       <= pos_nxt;
        i2s_lrclk <= (pos_nxt >= POS_RIGHT) ? LRCLK_RIGHT : LRCLK_LEFT;
        i2s_sdata <= shreg[FW-1];
        if (frame_load) begin
          // An empty buffer sends a silent frame and flags the underrun.
          shreg    <= in_ready ? '0 : {held_left, held_right};
          underrun <= in_ready;
        end else begin
          shreg <= {shreg[FW-2:0], 1'b0};
        end
      end
    end
  end

  // Holding buffer. A transfer on the same edge as a frame load sees the
  // buffer as empty for that load and waits for the next frame.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      in_ready   <= 1'b1;
      held_left  <= '0;
      held_right <= '0;
    end else if (frame_load && !in_ready) begin
      in_ready <= 1'b1;
    end else if (accept) begin
      held_left  <= in_left;
      held_right <= in_right;
      in_ready   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: one instance at BCLK_DIV=2 for the main
// scenarios and one at BCLK_DIV=1 for the fastest divider setting.
module tb_i2s_tx;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  logic [W-1:0] in_left, in_right;
  logic         in_valid, in_ready;
  logic         bclk, lrclk, sdata, underrun;

  logic [W-1:0] in_left1, in_right1;
  logic         in_valid1, in_ready1;
  logic         bclk1, lrclk1, sdata1, underrun1;

  int vectors;
  int miscompares;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_WIDTH(W), .BCLK_DIV(2)) dut (
    .clk       (clk),
    .RST       (rst_n),
    .in_left   (in_left),
    .in_right  (in_right),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i2s_bclk  (bclk),
    .i2s_lrclk (lrclk),
    .i2s_sdata (sdata),
    .underrun  (underrun)
  );

  i2s_tx #(.SAMPLE_WIDTH(W), .BCLK_DIV(1)) dut1 (
    .clk       (clk),
    .RST       (rst_n),
    .in_left   (in_left1),
    .in_right  (in_right1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .i2s_bclk  (bclk1),
    .i2s_lrclk (lrclk1),
    .i2s_sdata (sdata1),
    .underrun  (underrun1)
  );

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for a few cycles, release on a falling edge: the next
  // rising edge is clk edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Collect 32 serial bits (pos 1..31 then next pos 0), one per BCLK period.
  task automatic capture(input int step, input bit use_fast, output logic [31:0] w);
    w = '0;
    for (int k = 0; k < 32; k++) begin
      tick(step);
      w = {w[30:0], use_fast ? sdata1 : sdata};
    end
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    logic [31:0] w;
    int          ur_cnt;
    logic        sd_or;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_left     = '0;
    in_right    = '0;
    in_valid1   = 1'b0;
    in_left1    = '0;
    in_right1   = '0;

    // Reset values
    #23;
    chk("rst_bclk",     bclk,     1'b0);
    chk("rst_lrclk",    lrclk,    1'b1);
    chk("rst_sdata",    sdata,    1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_underrun", underrun, 1'b0);

    // Idle timing after release, no input
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("s1_bclk_e1",  bclk,  1'b0);
    chk("s1_bclk1_e1", bclk1, 1'b1);
    tick(1);
    chk("s1_bclk_e2",  bclk,  1'b1);
    chk("s1_bclk1_e2", bclk1, 1'b0);
    tick(1);
    chk("s1_bclk_e3",  bclk,  1'b1);
    chk("s1_bclk1_e3", bclk1, 1'b1);
    tick(1);
    chk("s1_bclk_e4",     bclk,     1'b0);
    chk("s1_lrclk_e4",    lrclk,    1'b0);
    chk("s1_underrun_e4", underrun, 1'b1);
    ur_cnt = 0;
    sd_or  = 1'b0;
    for (int e = 5; e <= 131; e++) begin
      tick(1);
      if (underrun) ur_cnt++;
      sd_or = sd_or | sdata;
    end
    chk("s1_no_underrun_between", ur_cnt, 0);
    chk("s1_sdata_quiet",         sd_or,  1'b0);
    tick(1);
    chk("s1_underrun_e132", underrun, 1'b1);

    // Single pair before the first frame
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_left  = 16'hA5F0;
    in_right = 16'h0F0F;
    do_reset();
    tick(1);
    chk("s2_ready_drop", in_ready, 1'b0);
    in_valid = 1'b0;
    in_left  = 16'hFFFF;
    tick(3);
    chk("s2_ready_e4",    in_ready, 1'b1);
    chk("s2_underrun_e4", underrun, 1'b0);
    w = '0;
    for (int k = 1; k <= 32; k++) begin
      tick(4);
      w = {w[30:0], sdata};
      if (k == 15) chk("s2_lrclk_pos15", lrclk, 1'b0);
      if (k == 16) begin
        chk("s2_lrclk_pos16", lrclk, 1'b1);
        chk("s2_sdata_pos16", sdata, 1'b0);
      end
    end
    chk("s2_frame_bits",    w,        32'hA5F00F0F);
    chk("s2_underrun_next", underrun, 1'b1);

    // Continuous supply
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_left  = 16'h1234;
    in_right = 16'h5678;
    do_reset();
    ur_cnt = 0;
    w      = '0;
    for (int e = 1; e <= 388; e++) begin
      tick(1);
      if (underrun) ur_cnt++;
      if (e == 1)   begin in_left = 16'hCAFE; in_right = 16'hBEEF; end
      if (e == 5)   begin in_left = 16'h0001; in_right = 16'h8000; end
      if (e == 133) begin in_left = 16'hFFFF; in_right = 16'hFFFF; end
      if (e == 4 || e == 132 || e == 260) chk("s3_ready_at_pos0", in_ready, 1'b1);
      if (e == 131 || e == 259)           chk("s3_ready_before_pos0", in_ready, 1'b0);
      if (e >= 136 && e <= 260 && (e % 4) == 0) w = {w[30:0], sdata};
      if (e == 260) chk("s3_frame1_bits", w, 32'hCAFEBEEF);
      if (e >= 264 && (e % 4) == 0) w = {w[30:0], sdata};
      if (e == 388) chk("s3_frame2_bits", w, 32'h00018000);
    end
    chk("s3_no_underrun", ur_cnt, 0);
    in_valid = 1'b0;

    // Accept on the same edge as a frame load
    rst_n = 1'b0;
    do_reset();
    tick(3);
    in_valid = 1'b1;
    in_left  = 16'h1357;
    in_right = 16'h2468;
    tick(1);
    chk("s4_underrun_e4", underrun, 1'b1);
    chk("s4_ready_e4",    in_ready, 1'b0);
    in_valid = 1'b0;
    capture(4, 1'b0, w);
    chk("s4_silent_frame",    w,        32'h0);
    chk("s4_underrun_e132",   underrun, 1'b0);
    chk("s4_ready_e132",      in_ready, 1'b1);
    capture(4, 1'b0, w);
    chk("s4_deferred_frame",  w,        32'h13572468);

    // Reset in the middle of a frame with a pair held
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_left  = 16'hAAAA;
    in_right = 16'hFFFF;
    do_reset();
    tick(1);
    in_left  = 16'h5555;
    in_right = 16'h0001;
    tick(4);
    in_valid = 1'b0;
    chk("s5_held_b", in_ready, 1'b0);
    tick(81);
    chk("s5_bclk_pos20",  bclk,  1'b1);
    chk("s5_sdata_pos20", sdata, 1'b1);
    chk("s5_lrclk_pos20", lrclk, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_bclk",     bclk,     1'b0);
    chk("s5_async_lrclk",    lrclk,    1'b1);
    chk("s5_async_sdata",    sdata,    1'b0);
    chk("s5_async_in_ready", in_ready, 1'b1);
    chk("s5_async_underrun", underrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("s5_bclk_e2", bclk, 1'b1);
    tick(2);
    chk("s5_bclk_e4",     bclk,     1'b0);
    chk("s5_underrun_e4", underrun, 1'b1);
    capture(4, 1'b0, w);
    chk("s5_old_pair_gone",  w,        32'h0);
    chk("s5_underrun_e132",  underrun, 1'b1);

    // Fastest divider
    rst_n     = 1'b0;
    in_valid1 = 1'b1;
    in_left1  = 16'h8001;
    in_right1 = 16'h0000;
    do_reset();
    tick(1);
    chk("s6_bclk1_e1",  bclk1,     1'b1);
    chk("s6_ready1_e1", in_ready1, 1'b0);
    in_valid1 = 1'b0;
    tick(1);
    chk("s6_bclk1_e2",     bclk1,     1'b0);
    chk("s6_lrclk1_e2",    lrclk1,    1'b0);
    chk("s6_underrun1_e2", underrun1, 1'b0);
    w = '0;
    for (int k = 1; k <= 32; k++) begin
      tick(2);
      w = {w[30:0], sdata1};
      if (k == 1)  chk("s6_sdata1_pos1",  sdata1, 1'b1);
      if (k == 16) chk("s6_sdata1_pos16", sdata1, 1'b1);
    end
    chk("s6_frame_bits", w, 32'h80010000);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
